fpu_mul_core: RTL
=================

FPU_MUL_CORE -- requirements
Module: fpu_mul_core

Interface
REQ-001 SHALL have no parameters; format fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 arst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  operation request from the main FPU sequencer; sampled only in idle.
REQ-005 a, b  input  32 each  binary32 operands; sampled with start.
REQ-006 ack  input  1  result consumed; sampled only while result_valid.
REQ-007 busy  output  1  high in every state except idle.
REQ-008 result_valid  output  1  result and flags stable; held until ack.
REQ-009 result  output  32  binary32 product.
REQ-010 flag_overflow, flag_underflow, flag_invalid  output  1 each  exception flags, valid with result_valid.

Function
REQ-011 SHALL use the state set idle, start, product_add, product_shift, result_set, result_valid.
REQ-012 idle: start=1 latches a, b -> start; start=0 stays idle.
REQ-013 start: unpack sign (a31^b31), exponents, 24-bit mantissas with hidden bit; special case -> result_set, else -> product_add with iteration counter 0.
REQ-014 product_add: if multiplier LSB=1, add multiplicand to upper half of 48-bit accumulator (carry kept) -> product_shift.
REQ-015 product_shift: shift accumulator/multiplier right 1, counter+1; counter reaching 24 -> result_set, else -> product_add.
REQ-016 result_set: normalise (bit47 set -> shift right 1, exponent+1), exponent = ea+eb-127, round, pack, set flags -> result_valid.
REQ-017 result_valid: ack=1 -> idle next cycle; ack=0 holds result and flags unchanged.
REQ-018 Latency: normal operands -> result_valid high exactly 51 cycles after the edge sampling start; special case -> 3 cycles.
REQ-019 start while busy SHALL be ignored (no latch, no queuing); ack outside result_valid SHALL be ignored.
REQ-020 Denormal inputs SHALL be treated as signed zero.
REQ-021 Special cases: NaN input or inf*0 -> 0x7FC00000, flag_invalid=1; inf*finite nonzero -> signed inf; zero*finite -> signed zero.
REQ-022 Biased exponent >=255 after rounding -> signed inf, flag_overflow=1.
REQ-023 Biased exponent <=0 -> signed zero, flag_underflow=1 (flush to zero).
REQ-024 Rounding carry out of mantissa SHALL renormalise (mantissa 1.0, exponent+1) and re-check overflow.
REQ-025 Flags SHALL be cleared at each accepted start.

Reset
REQ-026 arst SHALL force idle immediately, including mid-operation; the aborted operation produces no result.
REQ-027 Reset values: busy=0, result_valid=0, result=0x00000000, all flags 0, accumulator and counter 0.

Configuration
REQ-028 Macro FPU_MUL_RNE_EN defined: round-to-nearest-even using guard and sticky bits of the discarded 23 product bits.
REQ-029 FPU_MUL_RNE_EN undefined: truncate (round toward zero); latency identical in both builds.

Structure
REQ-030 State enum e_mul_state and binary32 field-width constants SHALL live in shared package pa_fpu; state enum SHALL NOT be redeclared locally.
REQ-031 Single module, no sub-modules; mantissa datapath and FSM in same file.

Verification
REQ-032 a=0x40000000, b=0x40400000, start pulse -> result=0x40C00000 at cycle 51, flags 0, held until ack, idle next cycle after ack.
REQ-033 a=0x3FC00001, b=0x3FC00001 -> 0x40100002 with FPU_MUL_RNE_EN, 0x40100001 without.
REQ-034 a=0x7F800000, b=0x00000000 -> 0x7FC00000, flag_invalid=1, result_valid at cycle 3.
REQ-035 a=0x7F000000, b=0x7F000000 -> 0x7F800000, flag_overflow=1; a=0x00800000, b=0x00800000 -> 0x00000000, flag_underflow=1.
REQ-036 arst pulse at cycle 20 of an operation -> busy=0, result_valid=0 immediately; start during busy with different operands -> original result unchanged.

Source files
------------

// File: rtl/pa_fpu.sv
// Shared binary32 field widths and the state enum of the multiplier core.
package pa_fpu;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned MUL_ITER = 24;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;
  localparam logic [FP_W-1:0]  QNAN         = 32'h7FC00000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PRODUCT_ADD,
    ST_PRODUCT_SHIFT,
    ST_RESULT_SET,
    ST_RESULT_VALID
  } e_mul_state;

endpackage

// File: rtl/fpu_mul_core.sv
// Sequential binary32 multiplier: shift-and-add mantissa product, flush-to-zero.
// Define FPU_MUL_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fpu_mul_core
  import pa_fpu::*;
(
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            start_i,
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [FP_W-1:0] result_o,
  output logic            flag_overflow_o,
  output logic            flag_underflow_o,
  output logic            flag_invalid_o
);

  e_mul_state state_q, state_d;
  logic [FP_W-1:0]   opA_q, opA_d, opB_q, opB_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  expA_q, expA_d, expB_q, expB_d;
  logic [MANT_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [PROD_W-1:0] accum_q, accum_d;
  logic              carry_q, carry_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              special_q, special_d;
  logic [FP_W-1:0]   specRes_q, specRes_d;
  logic              specInv_q, specInv_d;
  logic [FP_W-1:0]   result_q, result_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  logic [EXP_W-1:0]  eA, eB;
  logic              nanA, nanB, infA, infB, zeroA, zeroB, opSign;
  logic              isSpecial, specInv;
  logic [FP_W-1:0]   specRes;

  logic              norm, roundUp, fracCarry;
  logic [FRAC_W-1:0] fracRaw, fracRnd;
  logic [9:0]        expSum;
  logic [FP_W-1:0]   packRes;
  logic              packOvf, packUnf;
`ifdef FPU_MUL_RNE_EN
  logic              guardBit, stickyBit;
`endif

  assign eA     = opA_q[30:23];
  assign eB     = opB_q[30:23];
  assign opSign = opA_q[31] ^ opB_q[31];
  assign nanA   = (eA == EXP_ALL_ONES) && (opA_q[22:0] != '0);
  assign nanB   = (eB == EXP_ALL_ONES) && (opB_q[22:0] != '0);
  assign infA   = (eA == EXP_ALL_ONES) && (opA_q[22:0] == '0);
  assign infB   = (eB == EXP_ALL_ONES) && (opB_q[22:0] == '0);
  assign zeroA  = (eA == '0);
  assign zeroB  = (eB == '0);

  // Denormals share the zero path because exponent 0 is classed as zero.
  always_comb begin
    isSpecial = 1'b1;
    specInv   = 1'b0;
    specRes   = '0;
    if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
      specRes = QNAN;
      specInv = 1'b1;
    end else if (infA || infB) begin
      specRes = {opSign, EXP_ALL_ONES, 23'd0};
    end else if (zeroA || zeroB) begin
      specRes = {opSign, 31'd0};
    end else begin
      isSpecial = 1'b0;
    end
  end

  // Hidden bit is always set, so a fraction carry-out means mantissa 1.0 at exponent+1.
  always_comb begin
    norm    = accum_q[PROD_W-1];
    fracRaw = norm ? accum_q[46:24] : accum_q[45:23];
`ifdef FPU_MUL_RNE_EN
    guardBit  = norm ? accum_q[23] : accum_q[22];
    stickyBit = norm ? |accum_q[22:0] : |accum_q[21:0];
    roundUp   = guardBit & (stickyBit | fracRaw[0]);
`else
    roundUp   = 1'b0;
`endif
    {fracCarry, fracRnd} = {1'b0, fracRaw} + {23'd0, roundUp};
    expSum  = {2'b00, expA_q} + {2'b00, expB_q} + {9'd0, norm} + {9'd0, fracCarry} - 10'd127;
    packOvf = 1'b0;
    packUnf = 1'b0;
    if ($signed(expSum) >= 10'sd255) begin
      packRes = {sign_q, EXP_ALL_ONES, 23'd0};
      packOvf = 1'b1;
    end else if ($signed(expSum) <= 10'sd0) begin
      packRes = {sign_q, 31'd0};
      packUnf = 1'b1;
    end else begin
      packRes = {sign_q, expSum[7:0], fracRnd};
    end
  end

  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    sign_d    = sign_q;
    expA_d    = expA_q;
    expB_d    = expB_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    accum_d   = accum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    specRes_d = specRes_q;
    specInv_d = specInv_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inv_d     = inv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          opA_d   = a_i;
          opB_d   = b_i;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        sign_d    = opSign;
        expA_d    = eA;
        expB_d    = eB;
        mcand_d   = {1'b1, opA_q[22:0]};
        mplier_d  = {1'b1, opB_q[22:0]};
        accum_d   = '0;
        carry_d   = 1'b0;
        cnt_d     = '0;
        special_d = isSpecial;
        specRes_d = specRes;
        specInv_d = specInv;
        state_d   = isSpecial ? ST_RESULT_SET : ST_PRODUCT_ADD;
      end
      ST_PRODUCT_ADD: begin
        if (mplier_q[0]) begin
          {carry_d, accum_d[47:24]} = {1'b0, accum_q[47:24]} + {1'b0, mcand_q};
        end
        state_d = ST_PRODUCT_SHIFT;
      end
      ST_PRODUCT_SHIFT: begin
        accum_d  = {carry_q, accum_q[PROD_W-1:1]};
        carry_d  = 1'b0;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        state_d  = (cnt_q == 5'(MUL_ITER - 1)) ? ST_RESULT_SET : ST_PRODUCT_ADD;
      end
      ST_RESULT_SET: begin
        if (special_q) begin
          result_d = specRes_q;
          inv_d    = specInv_q;
        end else begin
          result_d = packRes;
          ovf_d    = packOvf;
          unf_d    = packUnf;
        end
        state_d = ST_RESULT_VALID;
      end
      ST_RESULT_VALID: begin
        if (ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      sign_q    <= 1'b0;
      expA_q    <= '0;
      expB_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      accum_q   <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      special_q <= 1'b0;
      specRes_q <= '0;
      specInv_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      sign_q    <= sign_d;
      expA_q    <= expA_d;
      expB_q    <= expB_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      accum_q   <= accum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      specRes_q <= specRes_d;
      specInv_q <= specInv_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      inv_q     <= inv_d;
    end
  end

  assign busy_o           = (state_q != ST_IDLE);
  assign result_valid_o   = (state_q == ST_RESULT_VALID);
  assign result_o         = result_q;
  assign flag_overflow_o  = ovf_q;
  assign flag_underflow_o = unf_q;
  assign flag_invalid_o   = inv_q;

endmodule
